// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the round-robin interrupt controller
package irq_pkg;

   typedef enum logic {IRQ_IDLE, IRQ_PEND} irq_state_t;

   localparam int N_IRQ_MAX      = 32;
   localparam int MCAUSE_INT_BIT = 31;

   // Index registers stay at least one bit wide even for a single request line
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - request/mask/handshake bundle between peripherals, core and controller
interface irq_controller_if
   import irq_pkg::*;
#(
   parameter int N_IRQ = 16
);

   logic [N_IRQ-1:0]          int_req_i;
   logic [N_IRQ-1:0]          mie_i;
   logic                      int_rst_i;
   logic                      int_o;
   logic [MCAUSE_INT_BIT:0]   mcause_o;
   logic [N_IRQ-1:0]          int_fin_o;

   modport master (
      input  int_req_i,
      input  mie_i,
      input  int_rst_i,
      output int_o,
      output mcause_o,
      output int_fin_o
   );

   modport slave (
      output int_req_i,
      output mie_i,
      output int_rst_i,
      input  int_o,
      input  mcause_o,
      input  int_fin_o
   );

endinterface

// File: rtl/irq_rr_pointer.sv
// rtl/irq_rr_pointer.sv - wrap-around scan pointer with hold, advance and load-next-after-index
module irq_rr_pointer
   import irq_pkg::*;
#(
   parameter int N_IRQ = 16,
   parameter int PTR_W = ptr_width(N_IRQ)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_advance,
   input  logic             i_load,
   input  logic [PTR_W-1:0] i_load_idx,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0] r_ptr;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
      return (v == PTR_W'(N_IRQ - 1)) ? '0 : v + PTR_W'(1);
   endfunction

   // Load wins over advance: after a service the scan restarts just past the serviced line
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= wrap_inc(i_load_idx);
      end else if (i_advance) begin
         r_ptr <= wrap_inc(r_ptr);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - round-robin interrupt controller feeding the core INT_/mcause inputs
module irq_controller
   import irq_pkg::*;
#(
   parameter int N_IRQ       = 16,
   parameter int MCAUSE_BASE = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   irq_controller_if.master    bus
);

   localparam int PTR_W = ptr_width(N_IRQ);

   irq_state_t                  r_state;
   irq_state_t                  w_state_nxt;
   logic [PTR_W-1:0]            w_ptr;
   logic [PTR_W-1:0]            r_idx;
   logic                        w_hit;
   logic                        w_capture;
   logic                        w_clear;
   logic                        w_advance;
   logic [MCAUSE_INT_BIT-1:0]   w_cause;
   logic                        r_int;
   logic [MCAUSE_INT_BIT:0]     r_mcause;
   logic [N_IRQ-1:0]            r_int_fin;

   assign w_hit   = bus.int_req_i[w_ptr] & bus.mie_i[w_ptr];
   assign w_cause = MCAUSE_INT_BIT'(MCAUSE_BASE) + MCAUSE_INT_BIT'(w_ptr);

   irq_rr_pointer #(
      .N_IRQ (N_IRQ),
      .PTR_W (PTR_W)
   ) u_ptr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_advance  (w_advance),
      .i_load     (w_clear),
      .i_load_idx (r_idx),
      .o_ptr      (w_ptr)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IRQ_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_clear     = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         IRQ_IDLE: begin
            if (w_hit) begin
               w_capture   = 1'b1;
               w_state_nxt = IRQ_PEND;
            end else begin
               w_advance   = 1'b1;
            end
         end
         IRQ_PEND: begin
            // Request and mask lines are ignored here; only the core's handler-done releases us
            if (bus.int_rst_i) begin
               w_clear     = 1'b1;
               w_state_nxt = IRQ_IDLE;
            end
         end
         default: w_state_nxt = IRQ_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_idx     <= '0;
         r_int     <= 1'b0;
         r_mcause  <= '0;
         r_int_fin <= '0;
      end else begin
         r_int_fin <= '0;
         if (w_capture) begin
            r_idx    <= w_ptr;
            r_int    <= 1'b1;
            r_mcause <= {1'b1, w_cause};
         end
         // mcause is deliberately left alone on clear so the core can still read it
         if (w_clear) begin
            r_int            <= 1'b0;
            r_int_fin[r_idx] <= 1'b1;
         end
      end
   end

   assign bus.int_o     = r_int;
   assign bus.mcause_o  = r_mcause;
   assign bus.int_fin_o = r_int_fin;

endmodule
